otter_fetch: RTL

//  Instruction fetch stage, directly downstream of the PC register. Takes the

---
 rtl/otter_fetch_pkg.sv | 25 ++
 rtl/otter_fetch_skid.sv | 50 +++++
 rtl/otter_fetch.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER instruction fetch stage.
package otter_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_VEC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD,
    FETCH_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/otter_fetch_skid.sv
// One-entry valid/ready skid buffer holding {pc, instr} behind the ir register.
// Used by otter_fetch only when OTTER_FETCH_SKID_EN is defined.
module otter_fetch_skid
  import otter_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_valid,
  input  fetch_pkt_t in_pkt,
  output logic       out_valid,
  output fetch_pkt_t out_pkt,
  input  logic       out_ready,
  output logic       full
);

  logic       sk_valid;
  fetch_pkt_t sk_pkt;

  assign full = sk_valid;

  // Upstream credit accounting guarantees no push arrives while both entries are full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pkt   <= '{pc: RESET_VEC, instr: NOP_INSTR};
      sk_valid  <= 1'b0;
      sk_pkt    <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      sk_valid  <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (sk_valid) begin
        out_valid <= 1'b1;
        out_pkt   <= sk_pkt;
        sk_valid  <= in_valid;
        if (in_valid) sk_pkt <= in_pkt;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_pkt <= in_pkt;
      end
    end else if (in_valid) begin
      sk_valid <= 1'b1;
      sk_pkt   <= in_pkt;
    end
  end

endmodule

// File: rtl/otter_fetch.sv
// OTTER instruction fetch: PC -> imem req/gnt/rvalid -> {ir, ir_pc} to decode.
// Optional OTTER_FETCH_SKID_EN: pipelined fetch with a one-entry skid buffer.
module otter_fetch
  import otter_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  output logic        pc_w_en,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  input  logic        ir_ready
);

  assign imem_addr = word_align(pc_addr);

`ifdef OTTER_FETCH_SKID_EN

  logic        started;
  logic        req_pend;
  logic [1:0]  live_cnt;
  logic [1:0]  drop_cnt;
  logic [31:0] resp_pc;
  logic        keep;
  logic        grant;
  logic        allowed;
  logic [1:0]  live_after;
  logic [2:0]  occ_after;
  logic        buf_full;
  fetch_pkt_t  buf_out;

  // Responses are kept only once all flushed requests have drained.
  assign keep       = imem_rvalid & (drop_cnt == 2'd0);
  assign live_after = 2'(live_cnt - 2'(keep));
  assign occ_after  = 3'(ir_valid) + 3'(buf_full) - 3'(ir_valid & ir_ready);
  assign allowed    = started
                    & ((3'(live_cnt) + 3'(drop_cnt)) < 3'd2)
                    & ((3'(live_cnt) + occ_after) < 3'd2);
  assign imem_req   = !flush & (req_pend | allowed);
  assign grant      = imem_req & imem_gnt;

  // The PC advances on grant so the next request can issue the following cycle.
  assign pc_w_en = flush | grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started  <= 1'b0;
      req_pend <= 1'b0;
      live_cnt <= 2'd0;
      drop_cnt <= 2'd0;
      resp_pc  <= RESET_VEC;
    end else begin
      started  <= 1'b1;
      req_pend <= imem_req & !imem_gnt;
      if (flush) begin
        drop_cnt <= 2'(3'(live_cnt) + 3'(drop_cnt) - 3'(imem_rvalid));
        live_cnt <= 2'd0;
      end else begin
        drop_cnt <= 2'(drop_cnt - 2'(imem_rvalid & (drop_cnt != 2'd0)));
        live_cnt <= 2'(live_after + 2'(grant));
        if (grant && live_after == 2'd0) resp_pc <= imem_addr;
        else if (keep)                   resp_pc <= resp_pc + 32'd4;
      end
    end
  end

  otter_fetch_skid #(
    .RESET_VEC(RESET_VEC)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .in_valid  (keep),
    .in_pkt    ('{pc: resp_pc, instr: imem_rdata}),
    .out_valid (ir_valid),
    .out_pkt   (buf_out),
    .out_ready (ir_ready),
    .full      (buf_full)
  );

  assign ir    = buf_out.instr;
  assign ir_pc = buf_out.pc;

`else

  fetch_state_e state;
  fetch_state_e state_n;
  logic         capture;
  logic         pc_adv;
  logic [31:0]  req_pc;

  // Next state; flush outranks gnt, rvalid and ir_ready.
  always_comb begin
    state_n = state;
    capture = 1'b0;
    unique case (state)
      FETCH_IDLE: state_n = FETCH_REQ;
      FETCH_REQ: begin
        if (flush)         state_n = imem_gnt ? FETCH_DROP : FETCH_REQ;
        else if (imem_gnt) state_n = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (flush) begin
          state_n = imem_rvalid ? FETCH_REQ : FETCH_DROP;
        end else if (imem_rvalid) begin
          state_n = FETCH_HOLD;
          capture = 1'b1;
        end
      end
      FETCH_HOLD: if (flush || ir_ready) state_n = FETCH_REQ;
      FETCH_DROP: if (imem_rvalid) state_n = FETCH_REQ;
      default:    state_n = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH_IDLE;
      imem_req <= 1'b0;
      pc_adv   <= 1'b0;
      ir_valid <= 1'b0;
      ir       <= NOP_INSTR;
      ir_pc    <= RESET_VEC;
      req_pc   <= RESET_VEC;
    end else begin
      state    <= state_n;
      imem_req <= (state_n == FETCH_REQ);
      pc_adv   <= capture;
      if (state == FETCH_REQ && imem_gnt && !flush) req_pc <= imem_addr;
      if (flush)                                 ir_valid <= 1'b0;
      else if (capture)                          ir_valid <= 1'b1;
      else if (state == FETCH_HOLD && ir_ready)  ir_valid <= 1'b0;
      if (capture) begin
        ir    <= imem_rdata;
        ir_pc <= req_pc;
      end
    end
  end

  // Redirect pulses combinationally so the PC holds the target by the next REQ.
  assign pc_w_en = pc_adv | flush;

`endif

endmodule
